// File: rtl/work_dispatcher.sv
// Work dispatcher: feeds one SHA-256 work unit to a mining core,
// then waits for a golden nonce or a timeout and reports the result.
module work_dispatcher #(
  parameter logic [31:0] TIMEOUT = 32'd4_000_000
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] midstate_in,
  input  logic [511:0] header_in,
  output logic         start_found,
  output logic         shift_in_enable,
  output logic [31:0]  in_data,
  input  logic         sol_claim,
  input  logic [31:0]  out_data,
  output logic         sol_response,
  input  logic         abort,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] MID    = 3'd2;
  localparam logic [2:0] HEAD   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] ACK    = 3'd5;
  localparam logic [2:0] REPORT = 3'd6;

  logic [2:0]   state, state_n;
  logic [3:0]   idx, idx_n;
  logic [31:0]  cnt, cnt_n;
  logic [255:0] mid_q, mid_n;
  logic [511:0] hdr_q, hdr_n;
  logic         found_n;
  logic [31:0]  nonce_n;
  logic [31:0]  word_n;
  logic         busy;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    mid_n   = mid_q;
    hdr_n   = hdr_q;
    found_n = result_found;
    nonce_n = result_nonce;
    busy    = (state == START) || (state == MID) ||
              (state == HEAD) || (state == WAIT) ||
              (state == ACK);
    unique case (state)
      IDLE: begin
        if (work_valid) begin
          mid_n   = midstate_in;
          hdr_n   = header_in;
          found_n = 1'b0;
          nonce_n = '0;
          state_n = START;
        end
      end
      START: begin
        idx_n   = '0;
        state_n = MID;
      end
      MID: begin
        if (idx == 4'd7) begin
          idx_n   = '0;
          state_n = HEAD;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      HEAD: begin
        if (idx == 4'd15) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      WAIT: begin
        cnt_n = cnt + 32'd1;
        // a claim on the final cycle still wins over the timeout
        if (sol_claim) begin
          found_n = 1'b1;
          nonce_n = out_data;
          state_n = ACK;
        end else if (cnt == TIMEOUT - 32'd1) begin
          found_n = 1'b0;
          nonce_n = '0;
          state_n = REPORT;
        end
      end
      ACK: begin
        state_n = REPORT;
      end
      REPORT: begin
        if (result_ready) begin
          found_n = 1'b0;
          nonce_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (abort && busy) begin
      found_n = 1'b0;
      nonce_n = '0;
      idx_n   = '0;
      state_n = IDLE;
    end
  end

  // word presented on in_data next cycle, chosen from next-state view
  always_comb begin
    word_n = '0;
    if (state_n == MID)
      word_n = mid_n[{~idx_n[2:0], 5'b0} +: 32];
    else if (state_n == HEAD)
      word_n = hdr_n[{~idx_n, 5'b0} +: 32];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      mid_q           <= '0;
      hdr_q           <= '0;
      work_ready      <= 1'b1;
      start_found     <= 1'b0;
      shift_in_enable <= 1'b0;
      in_data         <= '0;
      sol_response    <= 1'b0;
      result_valid    <= 1'b0;
      result_found    <= 1'b0;
      result_nonce    <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      cnt             <= cnt_n;
      mid_q           <= mid_n;
      hdr_q           <= hdr_n;
      work_ready      <= (state_n == IDLE);
      start_found     <= (state_n == START);
      shift_in_enable <= (state_n == MID) || (state_n == HEAD);
      in_data         <= word_n;
      sol_response    <= (state_n == ACK);
      result_valid    <= (state_n == REPORT);
      result_found    <= found_n;
      result_nonce    <= nonce_n;
    end
  end

endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized bench for work_dispatcher against a job-level
// reference model (word stream, claim/timeout outcome).
module tb_work_dispatcher;

  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] midstate_in;
  logic [511:0] header_in;
  logic         start_found;
  logic         shift_in_enable;
  logic [31:0]  in_data;
  logic         sol_claim;
  logic [31:0]  out_data;
  logic         sol_response;
  logic         abort;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [31:0]  result_nonce;

  int vecs = 0;
  int errs = 0;

  work_dispatcher #(.TIMEOUT(32'd10)) dut (
    .clk(clk), .n_rst(n_rst),
    .work_valid(work_valid), .work_ready(work_ready),
    .midstate_in(midstate_in), .header_in(header_in),
    .start_found(start_found),
    .shift_in_enable(shift_in_enable), .in_data(in_data),
    .sol_claim(sol_claim), .out_data(out_data),
    .sol_response(sol_response), .abort(abort),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_found(result_found), .result_nonce(result_nonce)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], $urandom()};
    return v;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], $urandom()};
    return v;
  endfunction

  task automatic test_reset;
    n_rst = 1'b0; work_valid = 0; sol_claim = 0; abort = 0;
    result_ready = 0; out_data = '0;
    midstate_in = '0; header_in = '0;
    tick; tick;
    vecs++;
    if ({work_ready, start_found, shift_in_enable, in_data,
         sol_response, result_valid, result_found, result_nonce}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL reset: wr=%b sf=%b se=%b d=%h sr=%b rv=%b rf=%b rn=%h",
               work_ready, start_found, shift_in_enable, in_data,
               sol_response, result_valid, result_found, result_nonce);
    end
    n_rst = 1'b1;
    tick;
    vecs++;
    if (work_ready !== 1'b1 || result_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: wr=%b rv=%b want 1 0",
               work_ready, result_valid);
    end
  endtask

  // kill_kind: 0 none, 1 abort, 2 reset at stream word kill_at
  task automatic run_job(input logic [255:0] mid,
                         input logic [511:0] hdr,
                         input int claim_at,
                         input logic [31:0] nonce,
                         input int hold,
                         input int kill_at,
                         input int kill_kind);
    logic [31:0] exp_w [24];
    logic        claimed;
    logic        exp_found;
    logic [31:0] exp_nonce;
    for (int i = 0; i < 8; i++) exp_w[i] = 32'(mid >> (32 * (7 - i)));
    for (int i = 0; i < 16; i++) exp_w[8 + i] = 32'(hdr >> (32 * (15 - i)));

    vecs++;
    if (work_ready !== 1'b1) begin
      errs++;
      $display("FAIL idle_ready: got %b want 1", work_ready);
    end
    work_valid = 1; midstate_in = mid; header_in = hdr;
    tick;
    work_valid = 0; midstate_in = rand256(); header_in = rand512();
    vecs++;
    if ({start_found, shift_in_enable, work_ready} !== 3'b100) begin
      errs++;
      $display("FAIL start: sf/se/wr=%b%b%b want 100",
               start_found, shift_in_enable, work_ready);
    end

    for (int i = 0; i < 24; i++) begin
      sol_claim = 1'($urandom()); out_data = $urandom();
      tick;
      vecs++;
      if ({shift_in_enable, start_found, sol_response, in_data}
          !== {1'b1, 1'b0, 1'b0, exp_w[i]}) begin
        errs++;
        $display("FAIL word[%0d]: se=%b sf=%b sr=%b d=%h want d=%h",
                 i, shift_in_enable, start_found, sol_response,
                 in_data, exp_w[i]);
      end
      if (kill_kind != 0 && i == kill_at) begin
        sol_claim = 0;
        if (kill_kind == 1) abort = 1; else n_rst = 0;
        tick;
        abort = 0; n_rst = 1;
        vecs++;
        if ({work_ready, start_found, shift_in_enable, in_data,
             sol_response, result_valid, result_found, result_nonce}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
          errs++;
          $display("FAIL kill%0d[%0d]: wr=%b se=%b d=%h rv=%b rf=%b rn=%h",
                   kill_kind, i, work_ready, shift_in_enable, in_data,
                   result_valid, result_found, result_nonce);
        end
        for (int k = 0; k < 3; k++) begin
          tick;
          vecs++;
          if ({result_valid, start_found, shift_in_enable, work_ready}
              !== 4'b0001) begin
            errs++;
            $display("FAIL kill_quiet[%0d]: rv/sf/se/wr=%b%b%b%b want 0001",
                     k, result_valid, start_found, shift_in_enable,
                     work_ready);
          end
        end
        return;
      end
    end

    claimed = 0;
    exp_found = 0;
    exp_nonce = '0;
    for (int k = 1; k <= TO && !claimed; k++) begin
      sol_claim = 0; out_data = $urandom();
      if (k > 1) tick;
      else tick;
      vecs++;
      if ({shift_in_enable, in_data, result_valid, sol_response}
          !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL wait[%0d]: se=%b d=%h rv=%b sr=%b want 0 0 0 0",
                 k, shift_in_enable, in_data, result_valid, sol_response);
      end
      if (k == claim_at) begin
        sol_claim = 1; out_data = nonce;
        claimed = 1; exp_found = 1; exp_nonce = nonce;
      end
    end
    tick;
    sol_claim = 0;
    if (claimed) begin
      vecs++;
      if ({sol_response, result_valid} !== 2'b10) begin
        errs++;
        $display("FAIL ack: sr/rv=%b%b want 10", sol_response, result_valid);
      end
      tick;
    end

    for (int h = 0; h <= hold; h++) begin
      vecs++;
      if ({result_valid, result_found, result_nonce, work_ready,
           sol_response, start_found}
          !== {1'b1, exp_found, exp_nonce, 1'b0, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL report[%0d]: rv=%b rf=%b rn=%h wr=%b sr=%b want rf=%b rn=%h",
                 h, result_valid, result_found, result_nonce, work_ready,
                 sol_response, exp_found, exp_nonce);
      end
      if (h == hold) begin
        result_ready = 1; work_valid = 0; abort = 0; sol_claim = 0;
      end else begin
        result_ready = 0;
        work_valid = 1'($urandom());
        abort = 1'($urandom());
        sol_claim = 1'($urandom());
        out_data = $urandom();
      end
      tick;
    end
    result_ready = 0;
    vecs++;
    if ({result_valid, work_ready, start_found} !== 3'b010) begin
      errs++;
      $display("FAIL handshake: rv/wr/sf=%b%b%b want 010",
               result_valid, work_ready, start_found);
    end
  endtask

  task automatic test_directed_found;
    logic [255:0] m;
    logic [511:0] h;
    m = '0; h = '0;
    for (int i = 1; i <= 8; i++) m = {m[223:0], 32'(i)};
    for (int i = 0; i < 16; i++) h = {h[479:0], 32'(32'h10 + i)};
    run_job(m, h, 3, 32'hDEADBEEF, 20, 0, 0);
  endtask

  task automatic test_timeout;
    run_job(rand256(), rand512(), 0, 32'h0, 20, 0, 0);
  endtask

  task automatic test_claim_last;
    run_job(rand256(), rand512(), TO, 32'hCAFE_F00D, 2, 0, 0);
  endtask

  task automatic test_abort;
    run_job(rand256(), rand512(), 0, 32'h0, 0, 12, 1);
  endtask

  task automatic test_reset_mid;
    run_job(rand256(), rand512(), 0, 32'h0, 0, 2, 2);
  endtask

  task automatic test_random;
    for (int j = 0; j < 25; j++) begin
      int c;
      int kk;
      c = int'($urandom_range(0, TO));
      kk = int'($urandom_range(0, 5));
      if (kk == 1)
        run_job(rand256(), rand512(), c, $urandom(),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 23)), 1);
      else
        run_job(rand256(), rand512(), c, $urandom(),
                int'($urandom_range(0, 4)), 0, 0);
    end
  endtask

  task automatic test_back_to_back;
    run_job(rand256(), rand512(), 1, $urandom(), 0, 0, 0);
    run_job(rand256(), rand512(), 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_directed_found;
    test_timeout;
    test_claim_last;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
